// File: rtl/decryptor.sv
// Iterative AES-128 decryptor: one inverse round per clock, with round keys supplied
// externally by a key expander that follows round_idx.
module decryptor #(
   parameter int ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] cipher_block,
   input  logic         cipher_block_vld,
   output logic         cipher_block_rdy,
   input  logic [127:0] key_round,
   output logic [3:0]   round_idx,
   output logic         warm_key,
   input  logic         flush,
   output logic [127:0] plain_block,
   output logic         plain_block_vld,
   input  logic         plain_block_rdy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUND = 2'd1;
   localparam logic [1:0] FINAL = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [3:0] ROUNDS_W = 4'(ROUNDS);

   localparam logic [0:255][7:0] INV_SBOX = {
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   logic [1:0]   cur_state;
   logic [3:0]   rcnt;
   logic [127:0] aes_state;
   logic [127:0] inv_round;
   logic [127:0] mixed;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte i lives at bits [127-8i -: 8]; i = 4*column + row.
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int rw = 0; rw < 4; rw++) begin
            r[127-8*(4*c+rw) -: 8] = INV_SBOX[s[127-8*(4*((c-rw+4)%4)+rw) -: 8]];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a [4];
      logic [7:0]   m9 [4];
      logic [7:0]   mb [4];
      logic [7:0]   md [4];
      logic [7:0]   me [4];
      logic [7:0]   x2, x4, x8;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int rw = 0; rw < 4; rw++) begin
            a[rw]  = s[127-8*(4*c+rw) -: 8];
            x2     = xtime(a[rw]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[rw] = x8 ^ a[rw];
            mb[rw] = x8 ^ x2 ^ a[rw];
            md[rw] = x8 ^ x4 ^ a[rw];
            me[rw] = x8 ^ x4 ^ x2;
         end
         r[127-8*(4*c+0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         r[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         r[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         r[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end
      return r;
   endfunction

   always_comb begin
      inv_round = inv_shift_sub(aes_state) ^ key_round;
      mixed     = inv_mix_columns(inv_round);
   end

   // rcnt holds at 1 on the last ROUND cycle so it never wraps; FINAL uses key 0 directly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_state       <= IDLE;
         rcnt            <= ROUNDS_W;
         aes_state       <= '0;
         plain_block     <= '0;
         plain_block_vld <= 1'b0;
      end else if (flush) begin
         cur_state       <= IDLE;
         rcnt            <= ROUNDS_W;
         plain_block_vld <= 1'b0;
      end else begin
         case (cur_state)
            IDLE: begin
               if (cipher_block_vld) begin
                  aes_state <= cipher_block ^ key_round;
                  rcnt      <= ROUNDS_W - 4'd1;
                  cur_state <= ROUND;
               end
            end
            ROUND: begin
               aes_state <= mixed;
               if (rcnt == 4'd1) begin
                  cur_state <= FINAL;
               end else begin
                  rcnt <= rcnt - 4'd1;
               end
            end
            FINAL: begin
               plain_block     <= inv_round;
               plain_block_vld <= 1'b1;
               rcnt            <= ROUNDS_W;
               cur_state       <= DONE;
            end
            DONE: begin
               if (plain_block_rdy) begin
                  plain_block_vld <= 1'b0;
                  cur_state       <= IDLE;
               end
            end
            default: cur_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      cipher_block_rdy = rst && (cur_state == IDLE) && !flush;
      warm_key = rst && ((cur_state == ROUND) || (cur_state == FINAL) ||
                         ((cur_state == IDLE) && cipher_block_vld));
      case (cur_state)
         ROUND:   round_idx = rcnt;
         FINAL:   round_idx = 4'd0;
         default: round_idx = ROUNDS_W;
      endcase
   end

endmodule
